memoredf_dispatcher: RTL and testbench
======================================

# memoredf_dispatcher

Downstream stage of the MemorEDF queue arbiter. It consumes the arbiter's `valid`/`selection` grant, pops exactly one entry from the granted per-master queue, and presents it on a registered valid/ready output channel toward the memory port. It sustains one transaction per cycle under continuous `m_ready`. It holds data stable under back-pressure.

## Interface
Parameters:
- `NUMBER_OF_QUEUES`, 4, number of input queues; must match the arbiter.
- `DATA_WIDTH`, 64, width of one queue entry.
- `COUNTER_WIDTH`, 32, width of each per-queue service counter.

Ports:
- `clock`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `empty`  in  NUMBER_OF_QUEUES  per-queue empty flags; same vector that feeds the arbiter.
- `queue_data`  in  NUMBER_OF_QUEUES×DATA_WIDTH  head entry of each queue; first-word-fall-through.
- `arb_valid`  in  1  arbiter grant valid.
- `arb_selection`  in  $clog2(NUMBER_OF_QUEUES)  granted queue index.
- `pop`  out  NUMBER_OF_QUEUES  one-hot, combinational; dequeues head of queue i this cycle.
- `m_valid`  out  1  output beat valid (registered).
- `m_ready`  in  1  consumer accepts beat.
- `m_data`  out  DATA_WIDTH  output beat payload (registered).
- `m_source`  out  $clog2(NUMBER_OF_QUEUES)  queue index the beat came from (registered).
- `busy`  out  1  equals `m_valid`.
- `served_count`  out  NUMBER_OF_QUEUES×COUNTER_WIDTH  per-queue count of dispatched entries.

## Operation
- FSM with two states:
  - IDLE: output register empty.
  - SEND: output register holds an unaccepted beat.
- `load` = `arb_valid` & `arb_selection` < NUMBER_OF_QUEUES & !`empty[arb_selection]` & (state==IDLE | `m_ready`).
- `pop[arb_selection]` = `load`; all other `pop` bits are 0. At most one bit is ever set.
- On `load`, the block captures the following on the next edge and enters or stays in SEND:
  - `m_data` <= `queue_data[arb_selection]`
  - `m_source` <= `arb_selection`
  - `m_valid` <= 1
- SEND & `m_ready` & !`load`: `m_valid` <= 0 and the FSM goes to IDLE. `m_data` and `m_source` keep their last values.
- SEND & !`m_ready`: `m_valid`, `m_data` and `m_source` are held stable. `pop` is 0 regardless of `arb_valid`.
- IDLE & !`load`: no change.
- Out-of-range `arb_selection` (non-power-of-2 queue count) is treated as no grant.
- A grant whose queue is flagged empty is ignored; no pop occurs.

## Timing
- Reset values: state IDLE; `m_valid`=0, `m_data`=0, `m_source`=0, `busy`=0, `served_count`=0. `pop`=0 while `reset` is high.
- Latency: a grant accepted in cycle t gives `m_valid`=1 with its data in cycle t+1.
- Throughput: 1 beat/cycle when `m_ready` is held high and the queues are non-empty. Handshake and the next load happen in the same cycle with no bubble.
- `m_valid` never drops without `m_ready` having been high in the preceding cycle, except on reset.
- Reset mid-transfer: the pending beat is discarded. Its entry has already been popped and is lost, which is accepted behaviour.
- `pop` is combinational from `empty`/`arb_*`/`m_ready`. The queue model must not create a path from `pop` back to `empty` in the same cycle.

## Configuration
- `MEMOREDF_DISPATCH_STATS_EN`:
  - Defined: `served_count[i]` increments by 1 on every cycle with `pop[i]`=1. It saturates at 2^COUNTER_WIDTH−1 and clears only on reset.
  - Undefined: no counter registers are built and `served_count` is tied to 0. Dispatch behaviour is otherwise identical.

## Test plan
- Reset, then drive `empty`=4'b1111 and `arb_valid`=0 for 10 cycles -> `pop`=0, `m_valid`=0, `m_data`=0 throughout.
- Queue 2 holds 0xA5, `arb_valid`=1, `arb_selection`=2, `m_ready`=1 -> `pop`=4'b0100 for one cycle; next cycle `m_valid`=1, `m_data`=0xA5, `m_source`=2; then `m_valid`=0.
- Hold `m_ready`=0 for 5 cycles with a beat pending and `arb_valid`=1 -> `pop`=0 and `m_data`/`m_source` unchanged for all 5 cycles. Raise `m_ready` -> the next grant loads in the handshake cycle.
- Keep `m_ready`=1 with queue 0 holding 8 entries granted continuously -> 8 consecutive `m_valid` beats, no bubbles, data in FIFO order.
- Assert `reset` while `m_valid`=1 and `m_ready`=0 -> next cycle `m_valid`=0 and `m_source`=0.
- With `MEMOREDF_DISPATCH_STATS_EN` and COUNTER_WIDTH=3, dispatch 9 entries from queue 1 -> `served_count[1]`=7, others 0. Without the macro -> all counters 0.

Source files
------------

// File: rtl/memoredf_dispatcher.sv
// MemorEDF dispatcher: pops the granted per-master queue and presents the entry on a registered valid/ready channel.
// Optional per-queue service counters are built when MEMOREDF_DISPATCH_STATS_EN is defined.
module memoredf_dispatcher #(
    parameter int unsigned NUMBER_OF_QUEUES = 4,
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned COUNTER_WIDTH    = 32,
    localparam int unsigned SEL_WIDTH       = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic [NUMBER_OF_QUEUES-1:0]               empty,
    input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0]    queue_data,
    input  logic                                      arb_valid,
    input  logic [SEL_WIDTH-1:0]                      arb_selection,
    output logic [NUMBER_OF_QUEUES-1:0]               pop,
    output logic                                      m_valid,
    input  logic                                      m_ready,
    output logic [DATA_WIDTH-1:0]                     m_data,
    output logic [SEL_WIDTH-1:0]                      m_source,
    output logic                                      busy,
    output logic [NUMBER_OF_QUEUES*COUNTER_WIDTH-1:0] served_count
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [SEL_WIDTH-1:0]    r_source;
    logic                    w_sel_hit;
    logic                    w_sel_empty;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_load;

    // Decode the grant; an index beyond the queue count matches nothing and reads as no grant.
    always_comb begin
        w_sel_hit   = 1'b0;
        w_sel_empty = 1'b1;
        w_sel_data  = '0;
        for (int unsigned i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (arb_selection == SEL_WIDTH'(i)) begin
                w_sel_hit   = 1'b1;
                w_sel_empty = empty[i];
                w_sel_data  = queue_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_load = !reset && arb_valid && w_sel_hit && !w_sel_empty
                    && ((r_state == IDLE) || m_ready);

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NUMBER_OF_QUEUES; i++) begin
            pop[i] = w_load && (arb_selection == SEL_WIDTH'(i));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A load wins over a drain so handshake and refill share one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_next_state = SEND;
                end
            end
            SEND: begin
                if (w_load) begin
                    w_next_state = SEND;
                end else if (m_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data   <= '0;
            r_source <= '0;
        end else if (w_load) begin
            r_data   <= w_sel_data;
            r_source <= arb_selection;
        end
    end

    assign m_valid  = (r_state == SEND);
    assign busy     = (r_state == SEND);
    assign m_data   = r_data;
    assign m_source = r_source;

`ifdef MEMOREDF_DISPATCH_STATS_EN
    logic [COUNTER_WIDTH-1:0] r_served [NUMBER_OF_QUEUES];

    // Saturating per-queue dispatch counters.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUMBER_OF_QUEUES; i++) begin
            if (reset) begin
                r_served[i] <= '0;
            end else if (pop[i] && (r_served[i] != {COUNTER_WIDTH{1'b1}})) begin
                r_served[i] <= r_served[i] + COUNTER_WIDTH'(1);
            end
        end
    end

    always_comb begin
        served_count = '0;
        for (int unsigned i = 0; i < NUMBER_OF_QUEUES; i++) begin
            served_count[i*COUNTER_WIDTH +: COUNTER_WIDTH] = r_served[i];
        end
    end
`else
    assign served_count = '0;
`endif

endmodule

// File: tb/tb_memoredf_dispatcher.sv
// Bench for memoredf_dispatcher: directed scenarios plus randomized traffic against a queue/transaction model.
module tb_memoredf_dispatcher;

    localparam int NQ = 4;
    localparam int DW = 64;
    localparam int CW = 3;
    localparam int DEPTH = 1024;

    logic              clock;
    logic              reset;
    logic [NQ-1:0]     empty;
    logic [NQ*DW-1:0]  queue_data;
    logic              arb_valid;
    logic [1:0]        arb_selection;
    logic [NQ-1:0]     pop;
    logic              m_valid;
    logic              m_ready;
    logic [DW-1:0]     m_data;
    logic [1:0]        m_source;
    logic              busy;
    logic [NQ*CW-1:0]  served_count;

    memoredf_dispatcher #(
        .NUMBER_OF_QUEUES(NQ),
        .DATA_WIDTH(DW),
        .COUNTER_WIDTH(CW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .empty(empty),
        .queue_data(queue_data),
        .arb_valid(arb_valid),
        .arb_selection(arb_selection),
        .pop(pop),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .m_source(m_source),
        .busy(busy),
        .served_count(served_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Queue model: FWFT FIFOs owned by the bench
    logic [DW-1:0] mem [NQ][DEPTH];
    int head [NQ];
    int tail [NQ];

    // Expected beat and pop counts
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [1:0]    e_src;
    int            served [NQ];
    logic [NQ-1:0] exp_pop;
    logic [NQ-1:0] act_pop;

    task automatic push(input int q, input logic [DW-1:0] v);
        if (tail[q] < DEPTH) begin
            mem[q][tail[q]] = v;
            tail[q]++;
        end
    endtask

    task automatic flush_all();
        for (int i = 0; i < NQ; i++) head[i] = tail[i];
    endtask

    task automatic drive_queues();
        for (int i = 0; i < NQ; i++) begin
            empty[i] = (head[i] == tail[i]);
            queue_data[i*DW +: DW] = empty[i] ? '0 : mem[i][head[i]];
        end
    endtask

    // One clock: predict pop from the grant rules, sample, advance the model, return at the negedge.
    task automatic cycle();
        int  s;
        bit  ok;
        drive_queues();
        #1;
        s  = int'(arb_selection);
        ok = !reset && arb_valid && (s < NQ) && (tail[s] != head[s]) && (!e_valid || m_ready);
        exp_pop = ok ? NQ'(1 << s) : '0;
        act_pop = pop;
        @(posedge clock);
        if (reset) begin
            e_valid = 1'b0;
            e_data  = '0;
            e_src   = '0;
            for (int i = 0; i < NQ; i++) served[i] = 0;
        end else if (ok) begin
            e_valid = 1'b1;
            e_data  = mem[s][head[s]];
            e_src   = 2'(s);
            head[s]++;
            served[s]++;
        end else if (e_valid && m_ready) begin
            e_valid = 1'b0;
        end
        @(negedge clock);
        drive_queues();
    endtask

    task automatic test_reset();
        reset = 1'b1; arb_valid = 1'b1; arb_selection = 2'd3; m_ready = 1'b1;
        push(3, 64'h11);
        repeat (3) begin
            cycle();
            checks++; if (act_pop !== 4'b0000) begin failures++; $display("FAIL reset_pop got=%b exp=0000", act_pop); end
            checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
            checks++; if (m_data !== 64'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", m_data); end
            checks++; if (m_source !== 2'd0) begin failures++; $display("FAIL reset_m_source got=%0d exp=0", m_source); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
            checks++; if (served_count !== '0) begin failures++; $display("FAIL reset_served got=%h exp=0", served_count); end
        end
        reset = 1'b0; arb_valid = 1'b0;
        flush_all();
    endtask

    task automatic test_idle();
        arb_valid = 1'b0; m_ready = 1'b1;
        repeat (10) begin
            cycle();
            checks++; if (empty !== 4'b1111) begin failures++; $display("FAIL idle_empty got=%b exp=1111", empty); end
            checks++; if (act_pop !== 4'b0000) begin failures++; $display("FAIL idle_pop got=%b exp=0000", act_pop); end
            checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL idle_m_valid got=%b exp=0", m_valid); end
            checks++; if (m_data !== 64'h0) begin failures++; $display("FAIL idle_m_data got=%h exp=0", m_data); end
        end
    endtask

    task automatic test_single();
        // Grant to an empty queue is ignored
        arb_valid = 1'b1; arb_selection = 2'd3; m_ready = 1'b1;
        cycle();
        checks++; if (act_pop !== 4'b0000) begin failures++; $display("FAIL empty_grant_pop got=%b exp=0000", act_pop); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL empty_grant_valid got=%b exp=0", m_valid); end
        push(2, 64'hA5);
        arb_selection = 2'd2;
        cycle();
        checks++; if (act_pop !== 4'b0100) begin failures++; $display("FAIL single_pop got=%b exp=0100", act_pop); end
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", m_valid); end
        checks++; if (m_data !== 64'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", m_data); end
        checks++; if (m_source !== 2'd2) begin failures++; $display("FAIL single_source got=%0d exp=2", m_source); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        cycle();
        checks++; if (act_pop !== 4'b0000) begin failures++; $display("FAIL single_pop2 got=%b exp=0000", act_pop); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL single_drop got=%b exp=0", m_valid); end
        checks++; if (m_data !== 64'hA5) begin failures++; $display("FAIL single_keep_data got=%h exp=a5", m_data); end
        arb_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        push(1, 64'h1111); push(1, 64'h2222); push(1, 64'h3333);
        arb_valid = 1'b1; arb_selection = 2'd1; m_ready = 1'b0;
        cycle();
        checks++; if (act_pop !== 4'b0010) begin failures++; $display("FAIL bp_first_pop got=%b exp=0010", act_pop); end
        checks++; if (m_data !== 64'h1111) begin failures++; $display("FAIL bp_first_data got=%h exp=1111", m_data); end
        repeat (5) begin
            cycle();
            checks++; if (act_pop !== 4'b0000) begin failures++; $display("FAIL bp_hold_pop got=%b exp=0000", act_pop); end
            checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b exp=1", m_valid); end
            checks++; if (m_data !== 64'h1111) begin failures++; $display("FAIL bp_hold_data got=%h exp=1111", m_data); end
            checks++; if (m_source !== 2'd1) begin failures++; $display("FAIL bp_hold_source got=%0d exp=1", m_source); end
        end
        m_ready = 1'b1;
        cycle();
        checks++; if (act_pop !== 4'b0010) begin failures++; $display("FAIL bp_release_pop got=%b exp=0010", act_pop); end
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_release_valid got=%b exp=1", m_valid); end
        checks++; if (m_data !== 64'h2222) begin failures++; $display("FAIL bp_release_data got=%h exp=2222", m_data); end
        arb_valid = 1'b0;
        cycle();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL bp_drain_valid got=%b exp=0", m_valid); end
        flush_all();
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] v [8];
        for (int k = 0; k < 8; k++) begin
            v[k] = {$urandom, $urandom};
            push(0, v[k]);
        end
        arb_valid = 1'b1; arb_selection = 2'd0; m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++; if (act_pop !== 4'b0001) begin failures++; $display("FAIL b2b_pop[%0d] got=%b exp=0001", k, act_pop); end
            checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", k, m_valid); end
            checks++; if (m_data !== v[k]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, m_data, v[k]); end
        end
        cycle();
        checks++; if (act_pop !== 4'b0000) begin failures++; $display("FAIL b2b_end_pop got=%b exp=0000", act_pop); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL b2b_end_valid got=%b exp=0", m_valid); end
        arb_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        push(2, 64'hBEEF);
        arb_valid = 1'b1; arb_selection = 2'd2; m_ready = 1'b0;
        cycle();
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b exp=1", m_valid); end
        arb_valid = 1'b0; reset = 1'b1;
        cycle();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", m_valid); end
        checks++; if (m_source !== 2'd0) begin failures++; $display("FAIL rstmid_source got=%0d exp=0", m_source); end
        checks++; if (m_data !== 64'h0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", m_data); end
        reset = 1'b0; m_ready = 1'b1;
        flush_all();
    endtask

    task automatic test_stats();
        logic [CW-1:0] exp1;
        reset = 1'b1; arb_valid = 1'b0;
        cycle();
        reset = 1'b0;
        for (int k = 0; k < 9; k++) push(1, 64'(k + 100));
        arb_valid = 1'b1; arb_selection = 2'd1; m_ready = 1'b1;
        repeat (9) cycle();
        arb_valid = 1'b0;
        cycle();
`ifdef MEMOREDF_DISPATCH_STATS_EN
        exp1 = 3'd7;
`else
        exp1 = 3'd0;
`endif
        for (int i = 0; i < NQ; i++) begin
            checks++;
            if (served_count[i*CW +: CW] !== ((i == 1) ? exp1 : 3'd0)) begin
                failures++;
                $display("FAIL stats_served[%0d] got=%0d exp=%0d", i, served_count[i*CW +: CW], (i == 1) ? exp1 : 3'd0);
            end
        end
    endtask

    task automatic test_random();
        int e;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 1) == 1) push(int'($urandom_range(0, NQ-1)), {$urandom, $urandom});
            arb_valid     = ($urandom_range(0, 3) != 0);
            arb_selection = 2'($urandom_range(0, 3));
            m_ready       = ($urandom_range(0, 9) < 7);
            reset         = ($urandom_range(0, 99) == 0);
            cycle();
            checks++; if (act_pop !== exp_pop) begin failures++; $display("FAIL rnd_pop[%0d] got=%b exp=%b", n, act_pop, exp_pop); end
            checks++; if (m_valid !== e_valid) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, m_valid, e_valid); end
            checks++; if (busy !== e_valid) begin failures++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", n, busy, e_valid); end
            checks++; if (m_data !== e_data) begin failures++; $display("FAIL rnd_data[%0d] got=%h exp=%h", n, m_data, e_data); end
            checks++; if (m_source !== e_src) begin failures++; $display("FAIL rnd_source[%0d] got=%0d exp=%0d", n, m_source, e_src); end
            for (int i = 0; i < NQ; i++) begin
                e = (served[i] > 7) ? 7 : served[i];
`ifndef MEMOREDF_DISPATCH_STATS_EN
                e = 0;
`endif
                checks++;
                if (served_count[i*CW +: CW] !== CW'(e)) begin
                    failures++;
                    $display("FAIL rnd_served[%0d][%0d] got=%0d exp=%0d", n, i, served_count[i*CW +: CW], e);
                end
            end
        end
        reset = 1'b0; arb_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arb_valid = 1'b0; arb_selection = 2'd0; m_ready = 1'b1;
        e_valid = 1'b0; e_data = '0; e_src = '0;
        for (int i = 0; i < NQ; i++) begin
            head[i] = 0; tail[i] = 0; served[i] = 0;
        end
        drive_queues();
        @(negedge clock);
        test_reset();
        test_idle();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_stats();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
